// File: rtl/approx_mul_err_monitor_if.sv
// ---------------------------------------------------------------------------
// approx_mul_err_monitor_if
//
// Sample bus between an approximate 8x8 multiplier tap and the error monitor.
//   in_valid : a sample is present on a / b / prod8
//   in_ready : the monitor takes the sample this cycle
//   a, b     : multiplier operands (unsigned 8-bit)
//   prod8    : approximate product under test (16-bit)
// Modports: master drives the sample, slave (the monitor) returns in_ready.
// ---------------------------------------------------------------------------
interface approx_mul_err_monitor_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] prod8;

  modport master (output in_valid, a, b, prod8, input in_ready);
  modport slave  (input in_valid, a, b, prod8, output in_ready);
endinterface

// File: rtl/approx_mul_err_monitor.sv
// ---------------------------------------------------------------------------
// approx_mul_err_monitor
//
// Characterises an approximate 8x8 multiplier. Each accepted sample has its
// exact product recomputed, the error distance ED = |a*b - prod8| derived, and
// the run statistics (error count, saturating ED sum, maximum ED) updated.
// A run covers N_SAMPLES accepted samples; statistics hold in DONE.
//
// Parameters:
//   N_SAMPLES : samples per run (1..65535)
//   ACC_W     : width of the saturating ED sum (8..48)
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : begin a new run; honoured only in IDLE or DONE
//   smp        : sample bus (slave modport: in_valid, a, b, prod8 in; in_ready out)
//   busy       : high while running or draining the pipeline
//   done       : high in DONE, statistics stable
//   err_cnt    : samples with ED != 0
//   sum_ed     : saturating sum of ED
//   max_ed     : maximum ED of the run
//   sample_cnt : samples accepted this run
//   sum_sq_ed  : saturating sum of ED*ED (only with ERR_MON_SQ_EN defined)
//
// Optional feature macro: ERR_MON_SQ_EN adds the ED-squared accumulator.
//
// Pipeline: accept edge registers exact product; next edge registers ED;
// the edge after that folds ED into the statistics.
// ---------------------------------------------------------------------------
module approx_mul_err_monitor #(
  parameter int unsigned N_SAMPLES = 256,
  parameter int unsigned ACC_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  approx_mul_err_monitor_if.slave smp,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             err_cnt,
  output logic [ACC_W-1:0]        sum_ed,
  output logic [15:0]             max_ed,
  output logic [15:0]             sample_cnt
`ifdef ERR_MON_SQ_EN
  ,
  output logic [ACC_W+15:0]       sum_sq_ed
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [15:0] LAST_IDX = 16'(N_SAMPLES - 1);

  // Sum is formed one bit wider than both operands so overflow is visible.
  localparam int SUM_W = ((ACC_W > 16) ? ACC_W : 16) + 1;
  localparam logic [SUM_W-1:0] SUM_MAX = (SUM_W'(1) << ACC_W) - SUM_W'(1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              accept;
  logic              last_accept;
  logic              run_entry;

  // Stage 1 / stage 2 pipeline registers
  logic              v1;
  logic [15:0]       exact1;
  logic [15:0]       prod1;
  logic              v2;
  logic [15:0]       ed2;
  logic              nz2;

  logic signed [16:0] diff;
  logic [15:0]        ed;
  logic [SUM_W-1:0]   sum_ext;

`ifdef ERR_MON_SQ_EN
  localparam int SQ_W = ((ACC_W + 16 > 32) ? ACC_W + 16 : 32) + 1;
  localparam logic [SQ_W-1:0] SQ_MAX = (SQ_W'(1) << (ACC_W + 16)) - SQ_W'(1);
  logic [31:0]     sq2;
  logic [SQ_W-1:0] sq_ext;
`endif

  assign smp.in_ready = (state == S_RUN);
  assign busy         = (state == S_RUN) || (state == S_DRAIN);
  assign done         = (state == S_DONE);
  assign accept       = smp.in_valid && smp.in_ready;
  assign last_accept  = accept && (sample_cnt == LAST_IDX);
  assign run_entry    = start && ((state == S_IDLE) || (state == S_DONE));

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)       state_nxt = S_RUN;
      S_RUN:   if (last_accept) state_nxt = S_DRAIN;
      // Once v1 is empty nothing follows the sample in v2, and this edge
      // commits v2 while clearing it, so both valid bits are 0 on entry to DONE.
      S_DRAIN: if (!v1)         state_nxt = S_DONE;
      S_DONE:  if (start)       state_nxt = S_RUN;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  // ED from a 17-bit signed difference; the magnitude always fits 16 bits.
  always_comb begin
    diff    = $signed({1'b0, exact1}) - $signed({1'b0, prod1});
    ed      = diff[16] ? 16'(-diff) : diff[15:0];
    sum_ext = SUM_W'(sum_ed) + SUM_W'(ed2);
`ifdef ERR_MON_SQ_EN
    sq_ext  = SQ_W'(sum_sq_ed) + SQ_W'(sq2);
`endif
  end

  // NOTE: state and pipeline registers use non-blocking assignments so every
  // flop samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      v1     <= 1'b0;
      exact1 <= 16'd0;
      prod1  <= 16'd0;
      v2     <= 1'b0;
      ed2    <= 16'd0;
      nz2    <= 1'b0;
`ifdef ERR_MON_SQ_EN
      sq2    <= 32'd0;
`endif
    end else begin
      state <= state_nxt;
      v1    <= accept;
      if (accept) begin
        exact1 <= {8'd0, smp.a} * {8'd0, smp.b};
        prod1  <= smp.prod8;
      end
      v2 <= v1;
      if (v1) begin
        ed2 <= ed;
        nz2 <= (ed != 16'd0);
`ifdef ERR_MON_SQ_EN
        sq2 <= {16'd0, ed} * {16'd0, ed};
`endif
      end
    end
  end

  // Statistics: cleared on the edge entering RUN, otherwise stage 3 of the
  // pipeline. v2 is always 0 in IDLE/DONE, so the clear never drops a sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt    <= 16'd0;
      sum_ed     <= '0;
      max_ed     <= 16'd0;
      sample_cnt <= 16'd0;
`ifdef ERR_MON_SQ_EN
      sum_sq_ed  <= '0;
`endif
    end else if (run_entry) begin
      err_cnt    <= 16'd0;
      sum_ed     <= '0;
      max_ed     <= 16'd0;
      sample_cnt <= 16'd0;
`ifdef ERR_MON_SQ_EN
      sum_sq_ed  <= '0;
`endif
    end else begin
      if (accept) sample_cnt <= sample_cnt + 16'd1;
      if (v2) begin
        err_cnt <= err_cnt + {15'd0, nz2};
        // Saturate at all-ones; once there, the sum stays put.
        sum_ed  <= (sum_ext > SUM_MAX) ? '1 : sum_ext[ACC_W-1:0];
        if (ed2 > max_ed) max_ed <= ed2;
`ifdef ERR_MON_SQ_EN
        sum_sq_ed <= (sq_ext > SQ_MAX) ? '1 : sq_ext[ACC_W+15:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// ---------------------------------------------------------------------------
// tb_approx_mul_err_monitor
//
// Drives runs of N samples into approx_mul_err_monitor. For each run the
// driver computes the expected final statistics and the cycle on which done
// must rise, and queues them; a separate monitor pops an entry whenever done
// rises and compares. The driver also checks in_ready/busy cycle by cycle.
// ---------------------------------------------------------------------------
module tb_approx_mul_err_monitor;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam longint unsigned SUM_MAX = (64'd1 << AW) - 64'd1;
  localparam longint unsigned SQ_MAX  = (64'd1 << (AW + 16)) - 64'd1;

  typedef struct {
    longint unsigned err;
    longint unsigned sum;
    longint unsigned mx;
    longint unsigned cnt;
    longint unsigned sq;
    int              done_cyc;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [15:0]   err_cnt;
  logic [AW-1:0] sum_ed;
  logic [15:0]   max_ed;
  logic [15:0]   sample_cnt;
`ifdef ERR_MON_SQ_EN
  logic [AW+15:0] sum_sq_ed;
`endif

  approx_mul_err_monitor_if bus ();

  approx_mul_err_monitor #(.N_SAMPLES(N), .ACC_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .smp        (bus),
    .busy       (busy),
    .done       (done),
    .err_cnt    (err_cnt),
    .sum_ed     (sum_ed),
    .max_ed     (max_ed),
    .sample_cnt (sample_cnt)
`ifdef ERR_MON_SQ_EN
    ,
    .sum_sq_ed  (sum_sq_ed)
`endif
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic done_prev = 1'b0;
  exp_t exp_q[$];
  int   sa[N];
  int   sb[N];
  int   sp[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference statistics straight from the definitions: |a*b - p|, count,
  // sum, max, sum of squares, then clamp to the accumulator ranges.
  function automatic exp_t model();
    exp_t            e;
    int              d;
    longint unsigned ed;
    e = '{default: 0};
    for (int i = 0; i < N; i++) begin
      d  = sa[i] * sb[i] - sp[i];
      ed = longint'((d < 0) ? -d : d);
      if (ed != 0) e.err++;
      e.sum += ed;
      e.sq  += ed * ed;
      if (ed > e.mx) e.mx = ed;
    end
    if (e.sum > SUM_MAX) e.sum = SUM_MAX;
    if (e.sq > SQ_MAX)   e.sq  = SQ_MAX;
    e.cnt = N;
    return e;
  endfunction

  task automatic gen_samples();
    int ex;
    int p;
    int d;
    for (int i = 0; i < N; i++) begin
      sa[i] = int'($urandom_range(0, 255));
      sb[i] = int'($urandom_range(0, 255));
      ex    = sa[i] * sb[i];
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: p = ex;
        9:             p = int'($urandom_range(0, 65535));
        default: begin
          d = int'($urandom_range(1, 40));
          p = ($urandom_range(0, 1) == 1) ? ex + d : ex - d;
        end
      endcase
      if (p < 0)     p = 0;
      if (p > 65535) p = 65535;
      sp[i] = p;
    end
  endtask

  task automatic drive_junk(input logic valid);
    bus.in_valid = valid;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    bus.prod8    = 16'($urandom);
  endtask

  // One complete run using sa/sb/sp. Called at a negedge in IDLE or DONE.
  // vpat gives in_valid per step (LSB first), then valid stays high.
  task automatic run(input logic [15:0] vpat, input bit poke, input string tag);
    exp_t e;
    int   acc;
    int   step;
    logic v;
    e    = model();
    acc  = 0;
    step = 0;
    check({tag, "_pre_ready"}, bus.in_ready, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_entry_ready"}, bus.in_ready, 1);
    check({tag, "_entry_busy"},  busy, 1);
    check({tag, "_entry_done"},  done, 0);
    check({tag, "_entry_cnt"},   sample_cnt, 0);
    check({tag, "_entry_sum"},   sum_ed, 0);
    check({tag, "_entry_max"},   max_ed, 0);
    check({tag, "_entry_err"},   err_cnt, 0);
    while (acc < N) begin
      v = (step < 16) ? vpat[step] : 1'b1;
      if (v) begin
        bus.in_valid = 1'b1;
        bus.a        = 8'(sa[acc]);
        bus.b        = 8'(sb[acc]);
        bus.prod8    = 16'(sp[acc]);
        acc++;
        if (acc == N) begin
          // Accept edge is the next posedge; done rises two edges later.
          e.done_cyc = cyc + 3;
          exp_q.push_back(e);
        end
      end else begin
        drive_junk(1'b0);
      end
      start = poke && (step == 1);
      step++;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_run_ready"}, bus.in_ready, (acc < N) ? 1 : 0);
      check({tag, "_run_busy"},  busy, 1);
      check({tag, "_run_cnt"},   sample_cnt, acc);
    end
    // Offered samples during DRAIN must be ignored.
    drive_junk(1'b1);
    @(negedge clk);
    check({tag, "_drain_ready"}, bus.in_ready, 0);
    check({tag, "_drain_busy"},  busy, 1);
    check({tag, "_drain_done"},  done, 0);
    check({tag, "_drain_cnt"},   sample_cnt, N);
    drive_junk(1'b0);
    @(negedge clk);
    check({tag, "_fin_busy"},  busy, 0);
    check({tag, "_fin_ready"}, bus.in_ready, 0);
    check({tag, "_fin_cnt"},   sample_cnt, N);
    drive_junk(1'b1);
    @(negedge clk);
    check({tag, "_hold_done"},  done, 1);
    check({tag, "_hold_ready"}, bus.in_ready, 0);
    check({tag, "_hold_cnt"},   sample_cnt, N);
    bus.in_valid = 1'b0;
  endtask

  // Monitor: whenever done rises, pop the oldest expectation and compare.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          check("sb_done_cycle", cyc, e.done_cyc);
          check("sb_err_cnt",    err_cnt, e.err);
          check("sb_sum_ed",     sum_ed, e.sum);
          check("sb_max_ed",     max_ed, e.mx);
          check("sb_sample_cnt", sample_cnt, e.cnt);
`ifdef ERR_MON_SQ_EN
          check("sb_sum_sq_ed",  sum_sq_ed, e.sq);
`endif
        end
      end
      done_prev = done;
    end
  end

  initial begin : driver
    bus.in_valid = 1'b0;
    bus.a        = 8'd0;
    bus.b        = 8'd0;
    bus.prod8    = 16'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", bus.in_ready, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_err",   err_cnt, 0);
    check("rst_sum",   sum_ed, 0);
    check("rst_max",   max_ed, 0);
    check("rst_cnt",   sample_cnt, 0);
    rst_n = 1'b1;
    drive_junk(1'b1);
    @(negedge clk);
    check("idle_ready", bus.in_ready, 0);
    check("idle_busy",  busy, 0);
    bus.in_valid = 1'b0;

    // Exact products only
    sa = '{15, 0, 255, 1};
    sb = '{15, 7, 255, 200};
    sp = '{225, 0, 65025, 200};
    run(16'hFFFF, 1'b0, "exact");
    check("exact_err", err_cnt, 0);
    check("exact_sum", sum_ed, 0);
    check("exact_max", max_ed, 0);

    // Known error run: EDs 3, 0, 5, 0
    sa = '{10, 3, 200, 1};
    sb = '{12, 3, 2, 1};
    sp = '{117, 9, 405, 1};
    run(16'hFFFF, 1'b0, "errrun");
    check("errrun_err", err_cnt, 2);
    check("errrun_sum", sum_ed, 8);
    check("errrun_max", max_ed, 5);
`ifdef ERR_MON_SQ_EN
    check("errrun_sq", sum_sq_ed, 34);
`endif

    // Handshake gaps 1,0,1,1,0,1 with a start pulse inside RUN
    gen_samples();
    run(16'h002D, 1'b1, "gaps");

    // Saturation of the 8-bit sum: EDs 200, 100, 0, 0
    sa = '{0, 0, 0, 0};
    sb = '{0, 0, 0, 0};
    sp = '{200, 100, 0, 0};
    run(16'hFFFF, 1'b0, "sat");
    check("sat_sum", sum_ed, 255);
    check("sat_max", max_ed, 200);
    check("sat_err", err_cnt, 2);

    // Reset mid-run after two accepts
    gen_samples();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 8'(sa[i]);
      bus.b        = 8'(sb[i]);
      bus.prod8    = 16'(sp[i]);
      @(negedge clk);
    end
    check("midrst_pre_cnt", sample_cnt, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", bus.in_ready, 0);
    check("midrst_busy",  busy, 0);
    check("midrst_done",  done, 0);
    check("midrst_err",   err_cnt, 0);
    check("midrst_sum",   sum_ed, 0);
    check("midrst_max",   max_ed, 0);
    check("midrst_cnt",   sample_cnt, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle_busy",  busy, 0);
    check("midrst_idle_ready", bus.in_ready, 0);
    gen_samples();
    run(16'hFFFF, 1'b0, "postrst");

    // Randomised runs, each started from DONE
    for (int r = 0; r < 20; r++) begin
      gen_samples();
      run(16'($urandom), ($urandom_range(0, 1) == 1), "rand");
    end

    repeat (4) @(negedge clk);
    check("pending_expectations", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
